// File: rtl/pipe_scene_renderer_if.sv
// pipe_scene_renderer_if: scan position, game control and pixel/event signals between game logic and the renderer
interface pipe_scene_renderer_if;
    logic       enable;
    logic       restart;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [9:0] bird_y;
    logic [2:0] rgb;
    logic       collision;
    logic       pipe_passed;
    modport master (
        output enable, restart, x_pos, y_pos, bird_y,
        input  rgb, collision, pipe_passed
    );
    modport slave (
        input  enable, restart, x_pos, y_pos, bird_y,
        output rgb, collision, pipe_passed
    );
endinterface

// File: rtl/pipe_scene_renderer.sv
// pipe_scene_renderer: renders sky, two scrolling pipe pairs and the bird, and reports collision and score events
module pipe_scene_renderer #(
    parameter int PIPE_W       = 32,
    parameter int GAP_H        = 120,
    parameter int GAP_MIN      = 60,
    parameter int SCROLL       = 2,
    parameter int BIRD_X       = 160,
    parameter int BIRD_S       = 16,
    parameter int PIPE_SPACING = 320
) (
    input logic                  pll,
    input logic                  rst,
    pipe_scene_renderer_if.slave bus
);
    localparam logic [10:0] SPAWN_R   = 11'(640 + PIPE_W);
    localparam logic [10:0] P1_INIT   = 11'(640 + PIPE_W + PIPE_SPACING);
    localparam logic [9:0]  G0_INIT   = 10'(GAP_MIN + 40);
    localparam logic [9:0]  G1_INIT   = 10'(GAP_MIN + 80);
    localparam logic [9:0]  GAP_MIN_W = 10'(GAP_MIN);
    localparam logic [10:0] GAP_H_W   = 11'(GAP_H);
    localparam logic [10:0] PIPE_W_W  = 11'(PIPE_W);
    localparam logic [10:0] SCROLL_W  = 11'(SCROLL);
    localparam logic [10:0] BIRD_X_W  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_S_W  = 11'(BIRD_S);
    logic [7:0]  lfsr_q, lfsr_d;
    logic [10:0] pipe_r_q [2];
    logic [10:0] pipe_r_d [2];
    logic [9:0]  gap_q [2];
    logic [9:0]  gap_d [2];
    logic [9:0]  bird_y_q, bird_y_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        collision_q, collision_d;
    logic        pipe_passed_q, pipe_passed_d;
    logic [10:0] x11, y11;
    logic        frame_tick, visible, bird_hit, pipe_hit, scroll;
    assign x11        = {1'b0, bus.x_pos};
    assign y11        = {1'b0, bus.y_pos};
    assign frame_tick = bus.x_pos == 10'd0 && bus.y_pos == 10'd480;
    assign visible    = bus.x_pos < 10'd640 && bus.y_pos < 10'd480;
    assign scroll     = frame_tick && bus.enable && !bus.restart;
    assign bird_hit   = x11 >= BIRD_X_W && x11 < BIRD_X_W + BIRD_S_W &&
                        y11 >= {1'b0, bird_y_q} && y11 < {1'b0, bird_y_q} + BIRD_S_W;
    always_comb begin
        pipe_hit = 1'b0;
        for (int i = 0; i < 2; i++)
            pipe_hit = pipe_hit || (x11 + PIPE_W_W >= pipe_r_q[i] && x11 < pipe_r_q[i] &&
                       (y11 < {1'b0, gap_q[i]} || y11 >= {1'b0, gap_q[i]} + GAP_H_W));
    end
    always_comb begin
        lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        bird_y_d      = frame_tick ? bus.bird_y : bird_y_q;
        rgb_d         = !visible ? 3'b000 : bird_hit ? 3'b110 : pipe_hit ? 3'b010 : 3'b011;
        collision_d   = bus.restart ? 1'b0 :
                        (bus.enable && ((visible && bird_hit && pipe_hit) ||
                        (frame_tick && {1'b0, bird_y_q} + BIRD_S_W > 11'd480))) ? 1'b1 : collision_q;
        pipe_passed_d = 1'b0;
        pipe_r_d      = pipe_r_q;
        gap_d         = gap_q;
        for (int i = 0; i < 2; i++) begin
            if (bus.restart) begin
                pipe_r_d[i] = (i == 0) ? SPAWN_R : P1_INIT;
                gap_d[i]    = (i == 0) ? G0_INIT : G1_INIT;
            end else if (scroll) begin
                pipe_r_d[i] = pipe_r_q[i] <= SCROLL_W ? SPAWN_R : pipe_r_q[i] - SCROLL_W;
                gap_d[i]    = pipe_r_q[i] <= SCROLL_W ? GAP_MIN_W + {3'b000, lfsr_q[7:1]} : gap_q[i];
                pipe_passed_d = pipe_passed_d || (pipe_r_q[i] > BIRD_X_W && pipe_r_d[i] <= BIRD_X_W);
            end
        end
    end
    always_ff @(posedge pll) begin
        if (rst) begin
            lfsr_q        <= 8'hA5;
            pipe_r_q      <= '{SPAWN_R, P1_INIT};
            gap_q         <= '{G0_INIT, G1_INIT};
            bird_y_q      <= '0;
            rgb_q         <= '0;
            collision_q   <= 1'b0;
            pipe_passed_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            pipe_r_q      <= pipe_r_d;
            gap_q         <= gap_d;
            bird_y_q      <= bird_y_d;
            rgb_q         <= rgb_d;
            collision_q   <= collision_d;
            pipe_passed_q <= pipe_passed_d;
        end
    end
    assign bus.rgb         = rgb_q;
    assign bus.collision   = collision_q;
    assign bus.pipe_passed = pipe_passed_q;
endmodule
